// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - pixel/window types shared by the window generator and kernel_1x5x5 consumers
package conv_pkg;
   localparam int DATA_W   = 32;
   localparam int KERNEL_K = 5;
   localparam int WIN_N    = KERNEL_K * KERNEL_K;

   typedef logic signed [DATA_W-1:0] pixel_t;
   typedef pixel_t [WIN_N-1:0]       window_t;

   function automatic int win_idx(input int r, input int c);
      return r * KERNEL_K + c;
   endfunction
endpackage

// File: rtl/window_gen_5x5_if.sv
// rtl/window_gen_5x5_if.sv - pixel-in / window-out handshake bundle (coordinates under WINDOW_GEN_COORD_EN)
interface window_gen_5x5_if;
   import conv_pkg::*;

   logic    in_valid;
   pixel_t  in_data;
   logic    in_ready;
   logic    win_valid;
   window_t win_data;
   logic    win_ready;
   logic    frame_done;
`ifdef WINDOW_GEN_COORD_EN
   logic [7:0] win_row;
   logic [7:0] win_col;
`endif

   modport slave (
      input  in_valid,
      input  in_data,
      input  win_ready,
      output in_ready,
      output win_valid,
      output win_data,
`ifdef WINDOW_GEN_COORD_EN
      output win_row,
      output win_col,
`endif
      output frame_done
   );

   modport master (
      output in_valid,
      output in_data,
      output win_ready,
      input  in_ready,
      input  win_valid,
      input  win_data,
`ifdef WINDOW_GEN_COORD_EN
      input  win_row,
      input  win_col,
`endif
      input  frame_done
   );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image row of delay, advancing only on accepted pixels
module line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 28
)
(
   input  logic   Clk,
   input  logic   Reset_n,
   input  logic   en,
   input  pixel_t din,
   output pixel_t dout
);
   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   pixel_t           mem [DEPTH];
   logic [PTR_W-1:0] ptr;

   // Read-before-write: the slot about to be overwritten holds the pixel from one row earlier.
   assign dout = mem[ptr];

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end
endmodule

// File: rtl/window_gen_5x5.sv
// rtl/window_gen_5x5.sv - raster pixels to 5x5 sliding windows; WINDOW_GEN_COORD_EN adds win_row/win_col
module window_gen_5x5
   import conv_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
)
(
   input  logic Clk,
   input  logic Reset_n,
   window_gen_5x5_if.slave bus
);
   localparam int               COL_W     = $clog2(IMG_W);
   localparam int               ROW_W     = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_K - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_K - 1);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             win_valid_q;
   logic             last_q;
   logic             frame_done_q;
   window_t          win_q;
   window_t          win_shift;
   pixel_t           tap [KERNEL_K];
   logic             accept;
   logic             win_hit;
   logic             at_end;

   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !win_valid_q || bus.win_ready;
   assign win_hit      = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
   assign at_end       = (row == ROW_LAST) && (col == COL_LAST);

   // tap[k] is the pixel k rows above the incoming one, same column.
   assign tap[0] = bus.in_data;

   for (genvar i = 0; i < KERNEL_K - 1; i++) begin : g_lb
      line_buffer #(.DEPTH(IMG_W)) u_lb (
         .Clk     (Clk),
         .Reset_n (Reset_n),
         .en      (accept),
         .din     (tap[i]),
         .dout    (tap[i+1])
      );
   end

   always_comb begin
      win_shift = win_q;
      for (int r = 0; r < KERNEL_K; r++) begin
         for (int c = 0; c < KERNEL_K - 1; c++) begin
            win_shift[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
         end
         win_shift[win_idx(r, KERNEL_K - 1)] = tap[KERNEL_K - 1 - r];
      end
   end

   // The shift window doubles as the output register: it only moves on accept,
   // and accept implies the presented window is either absent or leaving this cycle.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         col          <= '0;
         row          <= '0;
         win_valid_q  <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         win_q        <= '0;
      end else begin
         frame_done_q <= win_valid_q && bus.win_ready && last_q;
         if (accept) begin
            win_q <= win_shift;
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (win_hit) begin
            win_valid_q <= 1'b1;
            last_q      <= at_end;
         end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
         end
      end
   end

   assign bus.win_valid  = win_valid_q;
   assign bus.win_data   = win_q;
   assign bus.frame_done = frame_done_q;

`ifdef WINDOW_GEN_COORD_EN
   logic [7:0] win_row_q;
   logic [7:0] win_col_q;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (win_hit) begin
         win_row_q <= 8'(row) - 8'(KERNEL_K - 1);
         win_col_q <= 8'(col) - 8'(KERNEL_K - 1);
      end
   end

   assign bus.win_row = win_row_q;
   assign bus.win_col = win_col_q;
`endif
endmodule

// File: tb/tb_window_gen_5x5.sv
// tb/tb_window_gen_5x5.sv - scoreboard bench for window_gen_5x5 against an image-array model
module tb_window_gen_5x5;
   import conv_pkg::*;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   window_gen_5x5_if bus ();

   window_gen_5x5 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   typedef struct {
      window_t w;
      int      r;
      int      c;
   } exp_t;

   exp_t    sb [$];
   exp_t    mon_e;
   pixel_t  img [IMG_H][IMG_W];
   int      tests   = 0;
   int      fails   = 0;
   int      win_cnt = 0;
   int      fd_cnt  = 0;
   bit      rnd_ready  = 1'b0;
   bit      fd_expect  = 1'b0;
   bit      stall_prev = 1'b0;
   window_t held;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_win(input string name, input window_t act, input window_t exp);
      int k;
      tests++;
      if (act !== exp) begin
         fails++;
         k = 0;
         while (k < WIN_N - 1 && act[k] === exp[k]) k++;
         $display("FAIL %s: entry %0d got %0d expected %0d", name, k, act[k], exp[k]);
      end
   endtask

   // Reference: the window ending at (row,col) is read straight out of the stored image.
   function automatic window_t model_win(input int row, input int col);
      window_t w;
      for (int r = 0; r < KERNEL_K; r++)
         for (int c = 0; c < KERNEL_K; c++)
            w[r * KERNEL_K + c] = img[row - 4 + r][col - 4 + c];
      return w;
   endfunction

   // Monitor: pops the scoreboard on every window transfer.
   always @(negedge Clk) begin
      if (!Reset_n) begin
         stall_prev = 1'b0;
         fd_expect  = 1'b0;
      end else begin
         chk("frame_done", bus.frame_done, fd_expect);
         if (bus.frame_done) fd_cnt++;
         fd_expect = 1'b0;
         if (stall_prev) begin
            chk("hold_valid", bus.win_valid, 1);
            chk_win("hold_data", bus.win_data, held);
         end
         if (bus.win_valid && bus.win_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk_win("window_data", bus.win_data, mon_e.w);
`ifdef WINDOW_GEN_COORD_EN
               chk("win_row", bus.win_row, mon_e.r - 4);
               chk("win_col", bus.win_col, mon_e.c - 4);
`endif
               win_cnt++;
               fd_expect = (mon_e.r == IMG_H - 1) && (mon_e.c == IMG_W - 1);
            end
         end
         stall_prev = bus.win_valid && !bus.win_ready;
         held       = bus.win_data;
      end
   end

   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (rnd_ready) bus.win_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_pix(input pixel_t p);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = p;
      @(negedge Clk);
      while (!bus.in_ready && n < 1000) begin
         n++;
         @(negedge Clk);
      end
      chk("accept_in_time", bus.in_ready, 1);
      @(posedge Clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic stall_check(input window_t exp_w, input pixel_t p);
      bus.win_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = p;
      repeat (10) begin
         @(negedge Clk);
         chk("stall_valid", bus.win_valid, 1);
         chk("stall_in_ready", bus.in_ready, 0);
         chk_win("stall_data", bus.win_data, exp_w);
      end
      @(posedge Clk);
      #1;
      bus.win_ready = 1'b1;
   endtask

   // pattern: 0 = r*IMG_W+c, 1 = random, 2 = zero frame with -5 at (4,4)
   task automatic send_frame(input int pattern, input bit gaps, input int stop_after,
                             input bit first_chk, input int stall_at);
      int n_pix;
      int r;
      int c;
      for (int rr = 0; rr < IMG_H; rr++)
         for (int cc = 0; cc < IMG_W; cc++)
            case (pattern)
               0:       img[rr][cc] = pixel_t'(rr * IMG_W + cc);
               1:       img[rr][cc] = pixel_t'($urandom);
               default: img[rr][cc] = (rr == 4 && cc == 4) ? pixel_t'(-5) : pixel_t'(0);
            endcase
      n_pix = (stop_after < 0) ? IMG_W * IMG_H : stop_after;
      for (int i = 0; i < n_pix; i++) begin
         r = i / IMG_W;
         c = i % IMG_W;
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge Clk);
            #1;
         end
         if (i == stall_at) stall_check(model_win(r, c - 1), img[r][c]);
         if (r >= 4 && c >= 4) sb.push_back('{model_win(r, c), r, c});
         send_pix(img[r][c]);
         if (first_chk && i == 115) chk("no_window_before_117", bus.win_valid, 0);
         if (first_chk && i == 116) begin
            chk("first_window_valid", bus.win_valid, 1);
            chk_win("first_window", bus.win_data, model_win(4, 4));
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      repeat (4) @(negedge Clk);
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_win_valid"}, bus.win_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_frame_done"}, bus.frame_done, 0);
      chk({tag, "_win_data_zero"}, bus.win_data == '0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.win_ready = 1'b1;
      Reset_n       = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      check_reset_state("reset");

      // Ramp frame, full throughput, with a 10-cycle stall at (6,10).
      win_cnt = 0;
      fd_cnt  = 0;
      send_frame(0, 1'b0, -1, 1'b1, 6 * IMG_W + 10);
      drain();
      chk("ramp_windows", win_cnt, 576);
      chk("ramp_frame_done", fd_cnt, 1);

      // Partial random frame, then reset mid-frame.
      send_frame(1, 1'b1, 300, 1'b0, -1);
      Reset_n = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      sb.delete();
      check_reset_state("midframe_reset");

      // Zero frame with a single negative pixel.
      win_cnt = 0;
      fd_cnt  = 0;
      send_frame(2, 1'b0, -1, 1'b1, -1);
      drain();
      chk("neg_windows", win_cnt, 576);
      chk("neg_frame_done", fd_cnt, 1);

      // Two back-to-back random frames with random valid gaps and ready toggling.
      win_cnt   = 0;
      fd_cnt    = 0;
      rnd_ready = 1'b1;
      send_frame(1, 1'b1, -1, 1'b0, -1);
      send_frame(1, 1'b1, -1, 1'b0, -1);
      drain();
      rnd_ready     = 1'b0;
      bus.win_ready = 1'b1;
      chk("b2b_windows", win_cnt, 1152);
      chk("b2b_frame_done", fd_cnt, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/window_gen_5x5.md
WINDOW_GEN_5X5 -- requirements
Module: window_gen_5x5

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels (>= 5).
REQ-002 Parameter IMG_H, default 28, image height in pixels (>= 5).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  in_data holds a pixel.
REQ-006 in_data  input  signed 32  pixel, raster order (row-major, top-left first).
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 win_valid  output  1  win_data holds a complete 5x5 window.
REQ-009 win_data  output  signed 32 x [24:0]  window, ordering per REQ-014.
REQ-010 win_ready  input  1  consumer (kernel_1x5x5 stage) takes the window.
REQ-011 frame_done  output  1  one-cycle pulse after the last window of a frame is accepted.

Function
REQ-012 A pixel beat is accepted when in_valid && in_ready; a window transfers when win_valid && win_ready.
REQ-013 Column/row counters advance per accepted pixel; the column wraps IMG_W-1 -> 0 with row increment; row wraps IMG_H-1 -> 0 at end of frame, with no idle cycle between frames.
REQ-014 win_data[r*5+c] SHALL equal pixel(row-4+r, col-4+c), where (row,col) is the newest pixel accepted; r,c in 0..4, matching row-major weight order.
REQ-015 A window is produced only for an accepted pixel with row >= 4 and col >= 4; (IMG_W-4)*(IMG_H-4) windows per frame (576 at defaults); no windows span row boundaries.
REQ-016 Latency: win_valid rises on the cycle after the acceptance of the window's bottom-right pixel.
REQ-017 win_valid and win_data SHALL hold stable while win_valid && !win_ready.
REQ-018 in_ready = !win_valid || win_ready (single output register, no bubble at full throughput, one pixel per cycle).
REQ-019 Accepting a new pixel and transferring the current window in the same cycle are both honoured; the new window replaces the old one with no loss.
REQ-020 Four rows of IMG_W pixels are kept in line storage plus a 5x5 register window; pixel values pass unmodified (no arithmetic, sign preserved).
REQ-021 frame_done pulses for exactly one cycle, the cycle after the transfer of window (IMG_H-1, IMG_W-1).

Reset
REQ-022 With Reset_n low at a rising edge: counters = 0, win_valid = 0, frame_done = 0, win_data = all 0, in_ready = 1 on the following cycle.
REQ-023 Reset mid-frame discards partial frame and pending window; the next accepted pixel is (0,0).
REQ-024 Line storage contents need not be cleared; stale data SHALL never appear in an emitted window.

Configuration
REQ-025 Macro WINDOW_GEN_COORD_EN: when defined, add outputs win_row (8 bits) and win_col (8 bits) giving the window's top-left coordinates, registered and stable with win_data; when undefined, these ports do not exist and behaviour is otherwise identical.

Structure
REQ-026 Package conv_pkg SHALL hold DATA_W = 32, KERNEL_K = 5, typedef pixel_t (signed DATA_W) and window_t (pixel_t [KERNEL_K*KERNEL_K-1:0]), shared with kernel_1x5x5 consumers.
REQ-027 Sub-module line_buffer (one row, IMG_W-deep delay, pixel_t wide, enable on pixel accept) instantiated four times in series.

Verification
REQ-028 Defaults, pixel(r,c)=r*28+c streamed, win_ready=1 -> first window after 117th beat: win_data[0]=0, [12]=58, [24]=116.
REQ-029 Full frame, win_ready=1 -> exactly 576 windows; last win_data[24]=783, [0]=667; frame_done single pulse after it.
REQ-030 Hold win_ready=0 for 10 cycles while window pending -> win_data/win_valid stable, in_ready=0, no pixel accepted.
REQ-031 Reset_n low for 1 cycle after 300 pixels, then new frame -> win_valid=0 after reset, first window again after 117 beats with values from new frame only.
REQ-032 in_data=-5 at (4,4) of a zero frame -> win_data[24]=-5 (0xFFFFFFFB), all other entries 0.
REQ-033 Back-to-back two frames, random in_valid/win_ready toggling -> 1152 windows matching scoreboard, 2 frame_done pulses.
